// File: rtl/data_bus_stall_bridge_if.sv
// Data-port bundle between the CPU, the stall bridge and the data memory.
// The bridge takes the master modport (it masters the memory bus and answers
// the CPU); the environment (CPU + memory) takes the slave modport.
interface data_bus_stall_bridge_if;
  // CPU side
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  // memory side
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;

  modport master (
    input  data_address, data_read, data_write, data_writedata,
    output data_readdata,
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_readdata, mem_waitrequest
  );

  modport slave (
    output data_address, data_read, data_write, data_writedata,
    input  data_readdata,
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_readdata, mem_waitrequest
  );
endinterface

// File: rtl/data_bus_stall_bridge.sv
// data_bus_stall_bridge: turns the CPU's single-cycle data port into a
// wait-request bus transaction, freezing the CPU via cpu_clock_enable while
// the access is in flight. Includes a timeout watchdog and sticky errors.
// Optional macro BRIDGE_STATS_EN adds read/write/stall counters; without it
// the counter ports are tied to zero.
module data_bus_stall_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERROR_READDATA = 32'hDEADBEEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sys_clock_enable,
  output logic                          cpu_clock_enable,
  data_bus_stall_bridge_if.master       bus,
  output logic                          timeout_error,
  output logic                          protocol_error,
  output logic [31:0]                   read_count,
  output logic [31:0]                   write_count,
  output logic [31:0]                   stall_cycles
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  state_t      state_r, state_s;
  logic        capture_s, done_s, abort_s, cpu_ce_s, req_s;
  logic        mem_read_r, mem_write_r;
  logic [31:0] mem_address_r, mem_writedata_r, rdata_r;
  logic [15:0] tmo_cnt_r;
  logic        timeout_error_r, protocol_error_r;

  assign req_s = bus.data_read | bus.data_write;

  // Next-state decode and CPU clock-enable gating.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    done_s    = 1'b0;
    abort_s   = 1'b0;
    cpu_ce_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // A pending request must not let the CPU advance this cycle.
        cpu_ce_s = sys_clock_enable & ~req_s;
        if (sys_clock_enable && req_s) begin
          capture_s = 1'b1;
          state_s   = BUSY;
        end else begin
          state_s   = IDLE;
        end
      end
      BUSY: begin
        cpu_ce_s = 1'b0;
        if (!bus.mem_waitrequest) begin
          done_s  = 1'b1;
          state_s = RELEASE;
        end else if (tmo_cnt_r == TMO_LAST) begin
          abort_s = 1'b1;
          state_s = RELEASE;
        end else begin
          state_s = BUSY;
        end
      end
      RELEASE: begin
        // Leaving only on an enabled edge guarantees the CPU consumes the data.
        cpu_ce_s = sys_clock_enable;
        if (sys_clock_enable) begin
          state_s = IDLE;
        end else begin
          state_s = RELEASE;
        end
      end
      default: begin
        cpu_ce_s = 1'b0;
        state_s  = IDLE;
      end
    endcase
  end

  // State register, bus strobes/holding registers, watchdog and sticky errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= IDLE;
      mem_read_r       <= 1'b0;
      mem_write_r      <= 1'b0;
      mem_address_r    <= 32'd0;
      mem_writedata_r  <= 32'd0;
      rdata_r          <= 32'd0;
      tmo_cnt_r        <= 16'd0;
      timeout_error_r  <= 1'b0;
      protocol_error_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (capture_s) begin
        // Write wins when both strobes are high.
        mem_address_r   <= bus.data_address;
        mem_writedata_r <= bus.data_writedata;
        mem_write_r     <= bus.data_write;
        mem_read_r      <= ~bus.data_write;
        tmo_cnt_r       <= 16'd0;
        if (bus.data_read && bus.data_write) begin
          protocol_error_r <= 1'b1;
        end
      end else if (done_s) begin
        if (mem_read_r) begin
          rdata_r <= bus.mem_readdata;
        end
        mem_read_r  <= 1'b0;
        mem_write_r <= 1'b0;
      end else if (abort_s) begin
        rdata_r         <= ERROR_READDATA;
        mem_read_r      <= 1'b0;
        mem_write_r     <= 1'b0;
        timeout_error_r <= 1'b1;
      end else if (state_r == BUSY) begin
        tmo_cnt_r <= tmo_cnt_r + 16'd1;
      end
    end
  end

`ifdef BRIDGE_STATS_EN
  logic [31:0] read_count_r, write_count_r, stall_cycles_r;

  // Access and stall statistics; counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_count_r   <= 32'd0;
      write_count_r  <= 32'd0;
      stall_cycles_r <= 32'd0;
    end else begin
      if ((done_s || abort_s) && mem_read_r) begin
        read_count_r <= read_count_r + 32'd1;
      end
      if ((done_s || abort_s) && mem_write_r) begin
        write_count_r <= write_count_r + 32'd1;
      end
      if (sys_clock_enable && !cpu_ce_s) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end
    end
  end

  assign read_count   = read_count_r;
  assign write_count  = write_count_r;
  assign stall_cycles = stall_cycles_r;
`else
  assign read_count   = 32'd0;
  assign write_count  = 32'd0;
  assign stall_cycles = 32'd0;
`endif

  assign cpu_clock_enable  = cpu_ce_s;
  assign bus.mem_read      = mem_read_r;
  assign bus.mem_write     = mem_write_r;
  assign bus.mem_address   = mem_address_r;
  assign bus.mem_writedata = mem_writedata_r;
  assign bus.data_readdata = (state_r == RELEASE) ? rdata_r : 32'd0;
  assign timeout_error     = timeout_error_r;
  assign protocol_error    = protocol_error_r;

endmodule

// File: tb/tb_data_bus_stall_bridge.sv
// Directed, table-driven bench for data_bus_stall_bridge (TIMEOUT_CYCLES=8).
module tb_data_bus_stall_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        sys_clock_enable;
  logic        cpu_clock_enable;
  logic        timeout_error, protocol_error;
  logic [31:0] read_count, write_count, stall_cycles;

  data_bus_stall_bridge_if bus_if ();

  data_bus_stall_bridge #(.TIMEOUT_CYCLES(8), .ERROR_READDATA(32'hDEADBEEF)) dut (
    .clk              (clk),
    .reset            (reset),
    .sys_clock_enable (sys_clock_enable),
    .cpu_clock_enable (cpu_clock_enable),
    .bus              (bus_if),
    .timeout_error    (timeout_error),
    .protocol_error   (protocol_error),
    .read_count       (read_count),
    .write_count      (write_count),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sce, rd, wr;
    logic [31:0] addr, wdata, mrdata;
    logic        mwait;
    logic        e_ce, e_mr, e_mw;
    logic        chk_bus;
    logic [31:0] e_addr, e_wdata;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(logic sce, logic rd, logic wr, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] mrdata, logic mwait,
                              logic e_ce, logic e_mr, logic e_mw, logic chk_bus,
                              logic [31:0] e_addr, logic [31:0] e_wdata,
                              logic chk_rd, logic [31:0] e_rd);
    vec_t v;
    v.sce = sce; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.mrdata = mrdata; v.mwait = mwait; v.e_ce = e_ce; v.e_mr = e_mr;
    v.e_mw = e_mw; v.chk_bus = chk_bus; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.chk_rd = chk_rd; v.e_rd = e_rd;
    return v;
  endfunction

  function automatic logic [31:0] stat(logic [31:0] v);
`ifdef BRIDGE_STATS_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(logic sce, logic rd, logic wr, logic [31:0] addr,
                       logic [31:0] wdata, logic [31:0] mrdata, logic mwait);
    sys_clock_enable       = sce;
    bus_if.data_read       = rd;
    bus_if.data_write      = wr;
    bus_if.data_address    = addr;
    bus_if.data_writedata  = wdata;
    bus_if.mem_readdata    = mrdata;
    bus_if.mem_waitrequest = mwait;
  endtask

  // One table row = one clock cycle: drive after negedge, check before posedge.
  task automatic run_rows(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      drive(vq[i].sce, vq[i].rd, vq[i].wr, vq[i].addr, vq[i].wdata,
            vq[i].mrdata, vq[i].mwait);
      #1;
      chk($sformatf("row%0d cpu_ce", i), {31'd0, cpu_clock_enable}, {31'd0, vq[i].e_ce});
      chk($sformatf("row%0d mem_read", i), {31'd0, bus_if.mem_read}, {31'd0, vq[i].e_mr});
      chk($sformatf("row%0d mem_write", i), {31'd0, bus_if.mem_write}, {31'd0, vq[i].e_mw});
      if (vq[i].chk_bus) begin
        chk($sformatf("row%0d mem_address", i), bus_if.mem_address, vq[i].e_addr);
        chk($sformatf("row%0d mem_writedata", i), bus_if.mem_writedata, vq[i].e_wdata);
      end
      if (vq[i].chk_rd) begin
        chk($sformatf("row%0d data_readdata", i), bus_if.data_readdata, vq[i].e_rd);
      end
    end
  endtask

  task automatic chk_stats(string tag, logic [31:0] r, logic [31:0] w, logic [31:0] s);
    chk({tag, " read_count"}, read_count, stat(r));
    chk({tag, " write_count"}, write_count, stat(w));
    chk({tag, " stall_cycles"}, stall_cycles, stat(s));
  endtask

  initial begin
    int busy_n;

    // A: single read, no wait (rows 0-3)
    vq.push_back(mk(1,1,0,32'h1000,0,0,0,                 0,0,0, 0,0,0, 1,0));
    vq.push_back(mk(1,1,0,32'h1000,0,32'h12345678,0,      0,1,0, 1,32'h1000,0, 1,0));
    vq.push_back(mk(1,1,0,32'h1000,0,0,0,                 1,0,0, 0,0,0, 1,32'h12345678));
    vq.push_back(mk(1,0,0,0,0,0,0,                        1,0,0, 0,0,0, 1,0));
    // B: write with 3 wait cycles (rows 4-10)
    vq.push_back(mk(1,0,1,32'h2004,32'hCAFEF00D,0,1,      0,0,0, 0,0,0, 1,0));
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(1,0,1,32'h2004,32'hCAFEF00D,0,1,    0,0,1, 1,32'h2004,32'hCAFEF00D, 1,0));
    vq.push_back(mk(1,0,1,32'h2004,32'hCAFEF00D,0,0,      0,0,1, 1,32'h2004,32'hCAFEF00D, 1,0));
    vq.push_back(mk(1,0,1,32'h2004,32'hCAFEF00D,0,0,      1,0,0, 0,0,0, 0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,                        1,0,0, 0,0,0, 1,0));
    // C: both strobes -> write (rows 11-14)
    vq.push_back(mk(1,1,1,32'h10,32'h55,0,0,              0,0,0, 0,0,0, 1,0));
    vq.push_back(mk(1,1,1,32'h10,32'h55,0,0,              0,0,1, 1,32'h10,32'h55, 1,0));
    vq.push_back(mk(1,1,1,32'h10,32'h55,0,0,              1,0,0, 0,0,0, 0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,                        1,0,0, 0,0,0, 1,0));
    // D: sys_clock_enable low around the access (rows 15-21)
    vq.push_back(mk(0,1,0,32'h40,0,0,0,                   0,0,0, 0,0,0, 1,0));
    vq.push_back(mk(1,1,0,32'h40,0,0,0,                   0,0,0, 0,0,0, 1,0));
    vq.push_back(mk(0,1,0,32'h40,0,32'h0BADF00D,0,        0,1,0, 1,32'h40,0, 1,0));
    vq.push_back(mk(0,1,0,32'h40,0,0,0,                   0,0,0, 0,0,0, 1,32'h0BADF00D));
    vq.push_back(mk(0,1,0,32'h40,0,0,0,                   0,0,0, 0,0,0, 1,32'h0BADF00D));
    vq.push_back(mk(1,1,0,32'h40,0,0,0,                   1,0,0, 0,0,0, 1,32'h0BADF00D));
    vq.push_back(mk(1,0,0,0,0,0,0,                        1,0,0, 0,0,0, 1,0));
    // E: read after mid-transaction reset (rows 22-25)
    vq.push_back(mk(1,1,0,32'h6000,0,0,0,                 0,0,0, 0,0,0, 1,0));
    vq.push_back(mk(1,1,0,32'h6000,0,32'hA5A55A5A,0,      0,1,0, 1,32'h6000,0, 1,0));
    vq.push_back(mk(1,1,0,32'h6000,0,0,0,                 1,0,0, 0,0,0, 1,32'hA5A55A5A));
    vq.push_back(mk(1,0,0,0,0,0,0,                        1,0,0, 0,0,0, 1,0));

    // Reset for two cycles
    reset = 1'b1;
    drive(1,0,0,0,0,0,0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset cpu_ce", {31'd0, cpu_clock_enable}, 32'd1);
    chk("reset mem_read", {31'd0, bus_if.mem_read}, 32'd0);
    chk("reset mem_write", {31'd0, bus_if.mem_write}, 32'd0);
    chk("reset timeout_error", {31'd0, timeout_error}, 32'd0);
    chk("reset protocol_error", {31'd0, protocol_error}, 32'd0);
    chk("reset data_readdata", bus_if.data_readdata, 32'd0);
    chk_stats("reset", 0, 0, 0);

    run_rows(0, 3);
    chk_stats("read", 1, 0, 2);
    run_rows(4, 10);
    chk_stats("write", 1, 1, 7);
    chk("write protocol_error", {31'd0, protocol_error}, 32'd0);
    run_rows(11, 14);
    chk("both protocol_error", {31'd0, protocol_error}, 32'd1);
    chk_stats("both", 1, 2, 9);
    run_rows(15, 21);
    chk_stats("pause", 2, 2, 10);
    chk("pause timeout_error", {31'd0, timeout_error}, 32'd0);

    // Timeout: waitrequest stuck high, expect 8 BUSY cycles then abort
    @(negedge clk);
    drive(1,1,0,32'h3000,0,32'h11111111,1);
    #1;
    chk("tmo idle cpu_ce", {31'd0, cpu_clock_enable}, 32'd0);
    busy_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (bus_if.mem_read) busy_n++;
      else break;
    end
    chk("tmo busy cycles", busy_n, 32'd8);
    chk("tmo data_readdata", bus_if.data_readdata, 32'hDEADBEEF);
    chk("tmo release cpu_ce", {31'd0, cpu_clock_enable}, 32'd1);
    chk("tmo timeout_error", {31'd0, timeout_error}, 32'd1);
    @(negedge clk);
    drive(1,0,0,0,0,0,0);
    repeat (3) @(negedge clk);
    #1;
    chk("tmo sticky", {31'd0, timeout_error}, 32'd1);
    chk("tmo idle mem_read", {31'd0, bus_if.mem_read}, 32'd0);
    chk_stats("tmo", 3, 2, 19);

    // Reset on the 2nd BUSY cycle of a stalled read
    @(negedge clk);
    drive(1,1,0,32'h5000,0,0,1);
    @(negedge clk);
    #1;
    chk("rst busy1 mem_read", {31'd0, bus_if.mem_read}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    drive(1,0,0,0,0,0,1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst mem_read", {31'd0, bus_if.mem_read}, 32'd0);
    chk("rst cpu_ce", {31'd0, cpu_clock_enable}, 32'd1);
    chk("rst data_readdata", bus_if.data_readdata, 32'd0);
    chk("rst timeout_error", {31'd0, timeout_error}, 32'd0);
    chk("rst protocol_error", {31'd0, protocol_error}, 32'd0);
    chk_stats("rst", 0, 0, 0);
    run_rows(22, 25);
    chk_stats("post-rst", 1, 0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
